// File: rtl/fsm_chk_pkg.sv
// Shared types and helpers for the FSM output checker: run-state encoding,
// coverage geometry and (cs,in) legality/indexing.
package fsm_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int         COV_W    = 9;
   localparam logic [1:0] CODE_LIM = 2'd3;

   function automatic logic is_legal(input logic [1:0] cs, input logic [1:0] sym);
      return (cs < CODE_LIM) && (sym < CODE_LIM);
   endfunction

   // Row-major (state, input) -> bit position; only meaningful for legal pairs.
   function automatic logic [3:0] cov_idx(input logic [1:0] cs, input logic [1:0] sym);
      return ({2'b00, cs} * 4'd3) + {2'b00, sym};
   endfunction

endpackage

// File: rtl/fsm_chk_if.sv
// Stimulus/observation bundle between the FSM stage driver and the checker.
interface fsm_chk_if #(
   parameter int CNT_W = 16
);
   import fsm_chk_pkg::*;

   logic             start;
   logic             stop;
   logic             valid;
   logic [1:0]       cs;
   logic [1:0]       in;
   logic [3:0]       out;
   logic [3:0]       exp_out;

   logic             busy;
   logic             done;
   logic [CNT_W-1:0] vec_count;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] ill_count;
   logic [CNT_W-1:0] first_err_idx;
   logic [3:0]       first_err_out;
   logic             first_err_vld;
   logic [COV_W-1:0] cov;
   logic             pass;

   modport master (
      output start, stop, valid, cs, in, out, exp_out,
      input  busy, done, vec_count, err_count, ill_count,
             first_err_idx, first_err_out, first_err_vld, cov, pass
   );

   modport slave (
      input  start, stop, valid, cs, in, out, exp_out,
      output busy, done, vec_count, err_count, ill_count,
             first_err_idx, first_err_out, first_err_vld, cov, pass
   );

endinterface

// File: rtl/fsm_chk_cov.sv
// Coverage bitmap: one sticky bit per legal (state, input) pair checked.
module fsm_chk_cov
   import fsm_chk_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             set_i,
   input  logic [1:0]       cs_i,
   input  logic [1:0]       sym_i,
   output logic [COV_W-1:0] cov_o
);

   logic [COV_W-1:0] cov_q;
   logic [COV_W-1:0] cov_d;

   always_comb begin
      cov_d = cov_q;
      if (clr_i) begin
         cov_d = '0;
      end else if (set_i && is_legal(cs_i, sym_i)) begin
         cov_d[cov_idx(cs_i, sym_i)] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cov_q <= '0;
      end else begin
         cov_q <= cov_d;
      end
   end

   assign cov_o = cov_q;

endmodule

// File: rtl/fsm_out_checker.sv
// Run-controlled monitor of the Mealy FSM stage: counts matches, mismatches and
// illegal codes, captures the first failure and tracks (state,input) coverage.
module fsm_out_checker
   import fsm_chk_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int NUM_VEC = 0
) (
   input logic       clk,
   input logic       reset,
   fsm_chk_if.slave  bus
);

   state_e           state_q;
   logic             busy_q;
   logic             done_q;
   logic [CNT_W-1:0] vec_q,  vec_d;
   logic [CNT_W-1:0] err_q,  err_d;
   logic [CNT_W-1:0] ill_q,  ill_d;
   logic [CNT_W-1:0] fidx_q, fidx_d;
   logic [3:0]       fout_q, fout_d;
   logic             fvld_q, fvld_d;
   logic [COV_W-1:0] cov;

   logic clr;
   logic chk;
   logic legal;
   logic last;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // A start always clears, so a vector arriving alongside it is dropped.
   assign clr   = bus.start;
   assign chk   = (state_q == ST_RUN) && bus.valid && !bus.start;
   assign legal = is_legal(bus.cs, bus.in);

   always_comb begin
      vec_d  = vec_q;
      err_d  = err_q;
      ill_d  = ill_q;
      fidx_d = fidx_q;
      fout_d = fout_q;
      fvld_d = fvld_q;
      if (clr) begin
         vec_d  = '0;
         err_d  = '0;
         ill_d  = '0;
         fidx_d = '0;
         fout_d = '0;
         fvld_d = 1'b0;
      end else if (chk) begin
         vec_d = sat_inc(vec_q);
         if (!legal) begin
            ill_d = sat_inc(ill_q);
         end else if (bus.out != bus.exp_out) begin
            err_d = sat_inc(err_q);
            if (!fvld_q) begin
               fidx_d = vec_q;
               fout_d = bus.out;
               fvld_d = 1'b1;
            end
         end
      end
   end

   assign last = chk && (NUM_VEC != 0) && (vec_d == CNT_W'(NUM_VEC));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (bus.start) begin
                  state_q <= ST_RUN;
               end else if (bus.stop || last) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.start) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vec_q  <= '0;
         err_q  <= '0;
         ill_q  <= '0;
         fidx_q <= '0;
         fout_q <= '0;
         fvld_q <= 1'b0;
      end else begin
         vec_q  <= vec_d;
         err_q  <= err_d;
         ill_q  <= ill_d;
         fidx_q <= fidx_d;
         fout_q <= fout_d;
         fvld_q <= fvld_d;
      end
   end

   fsm_chk_cov u_cov (
      .clk   (clk),
      .reset (reset),
      .clr_i (clr),
      .set_i (chk),
      .cs_i  (bus.cs),
      .sym_i (bus.in),
      .cov_o (cov)
   );

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.vec_count     = vec_q;
   assign bus.err_count     = err_q;
   assign bus.ill_count     = ill_q;
   assign bus.first_err_idx = fidx_q;
   assign bus.first_err_out = fout_q;
   assign bus.first_err_vld = fvld_q;
   assign bus.cov           = cov;
   assign bus.pass          = done_q && (err_q == '0) && (ill_q == '0) && (cov == '1);

endmodule

// File: tb/tb_fsm_out_checker.sv
// Bench for fsm_out_checker: an unlimited-run DUT and a NUM_VEC=4 DUT share the
// same stimulus; each is compared against its own behavioural run model.
module tb_fsm_out_checker;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fsm_chk_if #(.CNT_W(16)) ia ();
   fsm_chk_if #(.CNT_W(16)) ib ();

   fsm_out_checker #(.CNT_W(16), .NUM_VEC(0)) u_a (.clk(clk), .reset(reset), .bus(ia));
   fsm_out_checker #(.CNT_W(16), .NUM_VEC(4)) u_b (.clk(clk), .reset(reset), .bus(ib));

   typedef struct {
      bit       running;
      bit       done;
      int       vec;
      int       err;
      int       ill;
      int       fidx;
      bit [3:0] fout;
      bit       fvld;
      bit [8:0] cov;
   } mdl_t;

   mdl_t ma, mb;

   logic [80:0] snap_a, snap_b;
   assign snap_a = {ia.busy, ia.done, ia.vec_count, ia.err_count, ia.ill_count, ia.first_err_idx,
                    ia.first_err_out, ia.first_err_vld, ia.cov, ia.pass};
   assign snap_b = {ib.busy, ib.done, ib.vec_count, ib.err_count, ib.ill_count, ib.first_err_idx,
                    ib.first_err_out, ib.first_err_vld, ib.cov, ib.pass};

   function automatic int sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   // One clock of a run, described by the rules rather than by any state encoding.
   function automatic mdl_t step(input mdl_t m, input int nv, input bit st, input bit sp, input bit v,
                                 input bit [1:0] c, input bit [1:0] s, input bit [3:0] o, input bit [3:0] e);
      mdl_t r;
      r = m;
      if (st) begin
         r = '{default: 0};
         r.running = 1'b1;
         return r;
      end
      if (!m.running) return r;
      if (v) begin
         r.vec = sat(m.vec);
         if (c == 2'd3 || s == 2'd3) begin
            r.ill = sat(m.ill);
         end else begin
            r.cov[int'(c) * 3 + int'(s)] = 1'b1;
            if (o != e) begin
               r.err = sat(m.err);
               if (!m.fvld) begin
                  r.fidx = m.vec;
                  r.fout = o;
                  r.fvld = 1'b1;
               end
            end
         end
      end
      if (sp || (nv != 0 && v && r.vec == nv)) begin
         r.running = 1'b0;
         r.done    = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [80:0] exp_snap(input mdl_t m);
      logic p;
      p = m.done && m.err == 0 && m.ill == 0 && m.cov == 9'h1FF;
      return {m.running, m.done, 16'(m.vec), 16'(m.err), 16'(m.ill), 16'(m.fidx), m.fout, m.fvld, m.cov, p};
   endfunction

   task automatic cyc(input bit st, input bit sp, input bit v, input bit [1:0] c, input bit [1:0] s,
                      input bit [3:0] o, input bit [3:0] e);
      ia.start = st; ia.stop = sp; ia.valid = v; ia.cs = c; ia.in = s; ia.out = o; ia.exp_out = e;
      ib.start = st; ib.stop = sp; ib.valid = v; ib.cs = c; ib.in = s; ib.out = o; ib.exp_out = e;
      @(posedge clk);
      if (reset) begin
         ma = '{default: 0};
         mb = '{default: 0};
      end else begin
         ma = step(ma, 0, st, sp, v, c, s, o, e);
         mb = step(mb, 4, st, sp, v, c, s, o, e);
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(1, 1, 1, 2'd1, 2'd1, 4'hA, 4'h5);
      cyc(0, 0, 0, 2'd0, 2'd0, 4'h0, 4'h0);
      reset = 1'b0;
      n_cmp++; if (snap_a !== 81'd0) begin n_fail++; $display("FAIL reset_a got %h want 0", snap_a); end
      n_cmp++; if (snap_b !== 81'd0) begin n_fail++; $display("FAIL reset_b got %h want 0", snap_b); end
   endtask

   task automatic test_all_pass();
      bit [3:0] d;
      cyc(1, 0, 0, 2'd0, 2'd0, 4'h0, 4'h0);
      n_cmp++; if (ia.busy !== 1'b1) begin n_fail++; $display("FAIL start_busy got %b want 1", ia.busy); end
      for (int i = 0; i < 9; i++) begin
         d = 4'($urandom);
         cyc(0, 0, 1, 2'(i / 3), 2'(i % 3), d, d);
      end
      cyc(0, 1, 0, 2'd0, 2'd0, 4'h0, 4'h0);
      n_cmp++; if (ia.vec_count !== 16'd9) begin n_fail++; $display("FAIL pass_vec got %0d want 9", ia.vec_count); end
      n_cmp++; if (ia.err_count !== 16'd0) begin n_fail++; $display("FAIL pass_err got %0d want 0", ia.err_count); end
      n_cmp++; if (ia.cov !== 9'h1FF) begin n_fail++; $display("FAIL pass_cov got %h want 1ff", ia.cov); end
      n_cmp++; if ({ia.pass, ia.done, ia.busy} !== 3'b110) begin n_fail++; $display("FAIL pass_flags got %b want 110", {ia.pass, ia.done, ia.busy}); end
      n_cmp++; if (snap_a !== exp_snap(ma)) begin n_fail++; $display("FAIL pass_model got %h want %h", snap_a, exp_snap(ma)); end
   endtask

   task automatic test_mismatch();
      cyc(1, 0, 0, 2'd0, 2'd0, 4'h0, 4'h0);
      for (int i = 0; i < 9; i++) begin
         if (i == 3 || i == 5) cyc(0, 0, 1, 2'(i / 3), 2'(i % 3), 4'hA, 4'h5);
         else                  cyc(0, 0, 1, 2'(i / 3), 2'(i % 3), 4'h7, 4'h7);
      end
      cyc(0, 1, 0, 2'd0, 2'd0, 4'h0, 4'h0);
      n_cmp++; if (ia.err_count !== 16'd2) begin n_fail++; $display("FAIL mm_err got %0d want 2", ia.err_count); end
      n_cmp++; if (ia.first_err_idx !== 16'd3) begin n_fail++; $display("FAIL mm_idx got %0d want 3", ia.first_err_idx); end
      n_cmp++; if ({ia.first_err_vld, ia.first_err_out} !== 5'h1A) begin n_fail++; $display("FAIL mm_out got %h want 1a", {ia.first_err_vld, ia.first_err_out}); end
      n_cmp++; if (ia.pass !== 1'b0) begin n_fail++; $display("FAIL mm_pass got %b want 0", ia.pass); end
   endtask

   task automatic test_illegal();
      cyc(1, 0, 0, 2'd0, 2'd0, 4'h0, 4'h0);
      for (int i = 0; i < 9; i++) cyc(0, 0, 1, 2'(i / 3), 2'(i % 3), 4'h3, 4'h3);
      cyc(0, 0, 1, 2'd3, 2'd0, 4'hA, 4'h5);
      cyc(0, 0, 1, 2'd1, 2'd3, 4'hA, 4'h5);
      cyc(0, 1, 0, 2'd0, 2'd0, 4'h0, 4'h0);
      n_cmp++; if (ia.ill_count !== 16'd2) begin n_fail++; $display("FAIL ill_cnt got %0d want 2", ia.ill_count); end
      n_cmp++; if (ia.err_count !== 16'd0) begin n_fail++; $display("FAIL ill_err got %0d want 0", ia.err_count); end
      n_cmp++; if (ia.vec_count !== 16'd11) begin n_fail++; $display("FAIL ill_vec got %0d want 11", ia.vec_count); end
      n_cmp++; if ({ia.cov, ia.pass} !== {9'h1FF, 1'b0}) begin n_fail++; $display("FAIL ill_cov got %h/%b want 1ff/0", ia.cov, ia.pass); end
   endtask

   task automatic test_num_vec();
      cyc(1, 0, 0, 2'd0, 2'd0, 4'h0, 4'h0);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 1, 2'(i % 3), 2'((i + 1) % 3), 4'h2, 4'h2);
         if (i == 2) begin
            n_cmp++; if (ib.done !== 1'b0) begin n_fail++; $display("FAIL nv_early got %b want 0", ib.done); end
         end
         if (i == 3) begin
            n_cmp++; if ({ib.done, ib.busy, ib.vec_count} !== {2'b10, 16'd4}) begin n_fail++; $display("FAIL nv_done got %b%b/%0d want 10/4", ib.done, ib.busy, ib.vec_count); end
         end
      end
      n_cmp++; if (ib.vec_count !== 16'd4) begin n_fail++; $display("FAIL nv_hold got %0d want 4", ib.vec_count); end
      n_cmp++; if (ia.vec_count !== 16'd6) begin n_fail++; $display("FAIL nv_unlim got %0d want 6", ia.vec_count); end
   endtask

   task automatic test_stop_mismatch();
      cyc(1, 0, 0, 2'd0, 2'd0, 4'h0, 4'h0);
      cyc(0, 1, 1, 2'd0, 2'd1, 4'hA, 4'h5);
      n_cmp++; if ({ia.done, ia.err_count, ia.first_err_idx} !== {1'b1, 16'd1, 16'd0}) begin n_fail++; $display("FAIL sm_count got %b/%0d/%0d want 1/1/0", ia.done, ia.err_count, ia.first_err_idx); end
      cyc(0, 0, 1, 2'd0, 2'd0, 4'hA, 4'h5);
      n_cmp++; if (ia.err_count !== 16'd1) begin n_fail++; $display("FAIL sm_frozen got %0d want 1", ia.err_count); end
      cyc(1, 0, 0, 2'd0, 2'd0, 4'h0, 4'h0);
      n_cmp++; if ({ia.busy, ia.done, ia.err_count, ia.vec_count, ia.first_err_vld} !== {2'b10, 32'd0, 1'b0}) begin n_fail++; $display("FAIL sm_restart got %b%b/%0d/%0d/%b want 10/0/0/0", ia.busy, ia.done, ia.err_count, ia.vec_count, ia.first_err_vld); end
   endtask

   task automatic test_reset_mid();
      cyc(1, 0, 0, 2'd0, 2'd0, 4'h0, 4'h0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 2'(i), 2'd2, 4'hA, 4'h5);
      n_cmp++; if (ia.err_count !== 16'd3) begin n_fail++; $display("FAIL rm_err got %0d want 3", ia.err_count); end
      reset = 1'b1;
      cyc(1, 0, 1, 2'd0, 2'd0, 4'hA, 4'h5);
      reset = 1'b0;
      n_cmp++; if (snap_a !== 81'd0) begin n_fail++; $display("FAIL rm_clear got %h want 0", snap_a); end
      cyc(0, 1, 1, 2'd0, 2'd0, 4'hA, 4'h5);
      n_cmp++; if ({ia.busy, ia.done, ia.vec_count} !== 18'd0) begin n_fail++; $display("FAIL rm_idle got %b%b/%0d want 00/0", ia.busy, ia.done, ia.vec_count); end
   endtask

   task automatic test_random();
      bit st, sp, v;
      bit [3:0] e, o;
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 299) == 0);
         st = ($urandom_range(0, 39) == 0);
         sp = ($urandom_range(0, 29) == 0);
         v  = ($urandom_range(0, 9) < 7);
         e  = 4'($urandom);
         o  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : e;
         cyc(st, sp, v, 2'($urandom), 2'($urandom), o, e);
         n_cmp++; if (snap_a !== exp_snap(ma)) begin n_fail++; $display("FAIL rnd_a cyc %0d got %h want %h", n, snap_a, exp_snap(ma)); end
         n_cmp++; if (snap_b !== exp_snap(mb)) begin n_fail++; $display("FAIL rnd_b cyc %0d got %h want %h", n, snap_b, exp_snap(mb)); end
      end
      reset = 1'b0;
   endtask

   initial begin
      ma = '{default: 0};
      mb = '{default: 0};
      test_reset();
      test_all_pass();
      test_mismatch();
      test_illegal();
      test_num_vec();
      test_stop_mismatch();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
